// File: rtl/mem_stream_pkg.sv
// rtl/mem_stream_pkg.sv - shared types for the memory stream reader
package mem_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - strided reads from a single-port memory, streamed out with valid/ready/last
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int DataDepth = 4096,
    parameter int AddrWidth = (DataDepth <= 1) ? 1 : $clog2(DataDepth)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic        [AddrWidth-1:0] base_addr_i,
    input  logic        [AddrWidth-1:0] stride_i,
    input  logic          [AddrWidth:0] length_i,
    output logic        [AddrWidth-1:0] mem_addr_o,
    output logic                        mem_we_o,
    output logic        [DataWidth-1:0] mem_wr_data_o,
    input  logic signed [DataWidth-1:0] mem_rd_data_i,
    output logic signed [DataWidth-1:0] data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        last_o,
    output logic                        busy_o,
    output logic                        done_o
);

    state_e               state_q;
    logic [AddrWidth-1:0] addr_q;
    logic [AddrWidth-1:0] stride_q;
    logic   [AddrWidth:0] remaining_q;
    logic                 primed_q;
    logic                 xfer;
    logic                 fetch;
    logic [AddrWidth-1:0] addr_next;

    assign mem_we_o      = 1'b0;
    assign mem_wr_data_o = '0;

    // primed_q spends the first RUN cycle letting the memory settle on the base address
    assign xfer      = valid_o && ready_i;
    assign fetch     = (state_q == RUN) && primed_q && (remaining_q != '0) && (!valid_o || ready_i);
    assign addr_next = addr_q + stride_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            stride_q    <= '0;
            remaining_q <= '0;
            primed_q    <= 1'b0;
            mem_addr_o  <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            last_o      <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (length_i != '0) begin
                            addr_q      <= base_addr_i;
                            mem_addr_o  <= base_addr_i;
                            stride_q    <= stride_i;
                            remaining_q <= length_i;
                            primed_q    <= 1'b0;
                            state_q     <= RUN;
                        end else begin
                            done_o  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    primed_q <= 1'b1;
                    if (fetch) begin
                        data_o      <= mem_rd_data_i;
                        valid_o     <= 1'b1;
                        last_o      <= (remaining_q == (AddrWidth+1)'(1));
                        addr_q      <= addr_next;
                        mem_addr_o  <= addr_next;
                        remaining_q <= remaining_q - 1'b1;
                    end else if (xfer) begin
                        valid_o <= 1'b0;
                        last_o  <= 1'b0;
                    end
                    if (xfer && remaining_q == '0) begin
                        done_o  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb/tb_mem_stream_reader.sv - directed self-checking bench for mem_stream_reader
module tb_mem_stream_reader;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic        [3:0] base;
    logic        [3:0] stride;
    logic        [4:0] length;
    logic        [3:0] mem_addr;
    logic              mem_we;
    logic        [7:0] mem_wr_data;
    logic signed [7:0] rd_data;
    logic signed [7:0] data;
    logic              valid;
    logic              ready;
    logic              last;
    logic              busy;
    logic              done;

    logic signed [7:0] mem [16];
    int                n_checks = 0;
    int                n_errors = 0;
    int                done_cnt = 0;
    logic        [8:0] seen_q[$];
    logic        [8:0] exp_q[$];

    always #5 clk = ~clk;

    mem_stream_reader #(
        .DataWidth(8),
        .DataDepth(16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .base_addr_i  (base),
        .stride_i     (stride),
        .length_i     (length),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_wr_data_o(mem_wr_data),
        .mem_rd_data_i(rd_data),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .last_o       (last),
        .busy_o       (busy),
        .done_o       (done)
    );

    assign rd_data = mem[mem_addr];

    // inputs change at posedge+2, so negedge sees the values the next edge will use
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) seen_q.push_back({last, data});
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic launch(input logic [3:0] b, input logic [3:0] s, input logic [4:0] l);
        start  = 1'b1;
        base   = b;
        stride = s;
        length = l;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_done_seen"}, done, 1);
        tick();
        check({tag, "_idle_after"}, busy, 0);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, seen_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
            check($sformatf("%s_word%0d", tag, i), seen_q[i], exp_q[i]);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
        rst_n  = 1'b0;
        start  = 1'b0;
        ready  = 1'b1;
        base   = '0;
        stride = '0;
        length = '0;
        tick();
        tick();
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_last", last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_we", mem_we, 0);
        check("rst_wdata", mem_wr_data, 0);
        rst_n = 1'b1;
        tick();

        // stride-1 stream, cycle by cycle
        seen_q.delete();
        done_cnt = 0;
        launch(4'd4, 4'd1, 5'd3);
        check("s1_busy_t", busy, 1);
        check("s1_valid_t", valid, 0);
        check("s1_addr_t", mem_addr, 4);
        tick();
        check("s1_valid_t1", valid, 0);
        tick();
        check("s1_valid_t2", valid, 1);
        check("s1_data_t2", data, 5);
        check("s1_last_t2", last, 0);
        tick();
        check("s1_data_t3", data, 6);
        check("s1_last_t3", last, 0);
        tick();
        check("s1_data_t4", data, 7);
        check("s1_last_t4", last, 1);
        tick();
        check("s1_valid_t5", valid, 0);
        check("s1_done_t5", done, 1);
        check("s1_busy_t5", busy, 1);
        tick();
        check("s1_done_t6", done, 0);
        check("s1_busy_t6", busy, 0);
        check("s1_done_cnt", done_cnt, 1);
        exp_q = '{9'h005, 9'h006, 9'h107};
        check_stream("s1");

        // backpressure on the second word
        seen_q.delete();
        done_cnt = 0;
        launch(4'd4, 4'd1, 5'd3);
        tick();
        tick();
        tick();
        check("bp_data_w2", data, 6);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp_hold_data%0d", i), data, 6);
            check($sformatf("bp_hold_valid%0d", i), valid, 1);
            check($sformatf("bp_hold_last%0d", i), last, 0);
        end
        ready = 1'b1;
        wait_done("bp", 10);
        check("bp_done_cnt", done_cnt, 1);
        exp_q = '{9'h005, 9'h006, 9'h107};
        check_stream("bp");

        // modulo wrap of the address
        seen_q.delete();
        launch(4'd14, 4'd3, 5'd3);
        check("wr_addr0", mem_addr, 14);
        tick();
        tick();
        check("wr_data0", data, 15);
        check("wr_addr1", mem_addr, 1);
        tick();
        check("wr_data1", data, 2);
        check("wr_addr2", mem_addr, 4);
        tick();
        check("wr_data2", data, 5);
        check("wr_last2", last, 1);
        wait_done("wr", 10);
        exp_q = '{9'h00F, 9'h002, 9'h105};
        check_stream("wr");

        // zero length goes straight to DONE
        seen_q.delete();
        done_cnt = 0;
        launch(4'd3, 4'd1, 5'd0);
        check("zl_done", done, 1);
        check("zl_busy", busy, 1);
        check("zl_valid", valid, 0);
        check("zl_addr_hold", mem_addr, 7);
        tick();
        check("zl_done_off", done, 0);
        check("zl_busy_off", busy, 0);
        check("zl_done_cnt", done_cnt, 1);
        check("zl_no_words", seen_q.size(), 0);

        // stride 0 re-reads one word
        seen_q.delete();
        launch(4'd7, 4'd0, 5'd2);
        wait_done("st0", 10);
        exp_q = '{9'h008, 9'h108};
        check_stream("st0");

        // ignored start mid-run, then abort by reset
        seen_q.delete();
        done_cnt = 0;
        launch(4'd0, 4'd1, 5'd8);
        tick();
        tick();
        check("ab_data0", data, 1);
        start  = 1'b1;
        base   = 4'd10;
        stride = 4'd5;
        length = 5'd2;
        tick();
        start = 1'b0;
        check("ab_data1", data, 2);
        tick();
        check("ab_data2", data, 3);
        check("ab_addr", mem_addr, 3);
        rst_n = 1'b0;
        #1;
        check("ab_valid_rst", valid, 0);
        check("ab_busy_rst", busy, 0);
        check("ab_data_rst", data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("ab_no_done", done_cnt, 0);
        check("ab_idle", busy, 0);

        seen_q.delete();
        done_cnt = 0;
        launch(4'd2, 4'd2, 5'd2);
        wait_done("rs", 10);
        check("rs_done_cnt", done_cnt, 1);
        exp_q = '{9'h003, 9'h105};
        check_stream("rs");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 SHALL have parameter DataWidth, default 8, memory word width in bits.
REQ-002 SHALL have parameter DataDepth, default 4096, memory depth in words; SHALL be a power of two.
REQ-003 SHALL have parameter AddrWidth, default (DataDepth <= 1) ? 1 : $clog2(DataDepth), address width.
REQ-004 SHALL have ports, in this order:
- clk_i  in  1  clock; one clock domain only.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  start request; sampled only in IDLE.
- base_addr_i  in  AddrWidth  first word address.
- stride_i  in  AddrWidth  address increment per word.
- length_i  in  AddrWidth+1  number of words to read (0..DataDepth).
- mem_addr_o  out  AddrWidth  address to the memory.
- mem_we_o  out  1  memory write enable; constant 0.
- mem_wr_data_o  out  DataWidth  memory write data; constant 0.
- mem_rd_data_i  in  DataWidth (signed)  combinational read data for mem_addr_o.
- data_o  out  DataWidth (signed)  streamed word.
- valid_o  out  1  data_o is valid.
- ready_i  in  1  downstream accepts data_o.
- last_o  out  1  data_o is the final word of the transfer.
- busy_o  out  1  a transfer is in progress.
- done_o  out  1  one-cycle pulse when the transfer completes.

Function
REQ-005 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-006 IDLE: if start_i=1 with length_i>0, SHALL latch base, stride and length, and SHALL go to RUN. If start_i=1 with length_i=0, SHALL go to DONE. Otherwise SHALL stay in IDLE.
REQ-007 In RUN, mem_addr_o SHALL equal the current address. Otherwise mem_addr_o SHALL hold its last value (0 after reset).
REQ-008 In RUN, a fetch SHALL occur when remaining>0 and (valid_o=0 or ready_i=1).
REQ-009 A fetch SHALL register mem_rd_data_i into data_o and set valid_o=1. It SHALL set last_o=1 iff remaining=1. It SHALL advance the address by stride_i modulo 2**AddrWidth and decrement remaining.
REQ-010 The output handshake SHALL be a transfer when valid_o=1 and ready_i=1 in the same cycle.
REQ-011 When a transfer occurs and no fetch occurs in that cycle, valid_o and last_o SHALL clear next cycle.
REQ-012 While valid_o=1 and ready_i=0, data_o, valid_o and last_o SHALL hold stable.
REQ-013 A transfer and a fetch in the same cycle SHALL sustain 1 word/cycle with no bubble.
REQ-014 Latency: for start_i accepted at edge t, the first valid_o=1 SHALL appear after edge t+2.
REQ-015 RUN SHALL go to DONE on the cycle the last word transfers (remaining=0, valid_o=1, ready_i=1).
REQ-016 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-017 busy_o SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-018 start_i while busy_o=1 SHALL be ignored, with no effect on the transfer or on the latched parameters.
REQ-019 Address wrap past DataDepth-1 SHALL be silent modulo wrap. stride_i=0 SHALL re-read the same word length_i times.

Reset
REQ-020 rst_ni=0 SHALL asynchronously force state IDLE and set all of the following to 0: mem_addr_o, data_o, valid_o, last_o, busy_o, done_o, internal address and remaining count.
REQ-021 Reset asserted mid-transfer SHALL abort it: no done_o pulse, and valid_o=0 from reset assertion.

Structure
REQ-022 The state enum (IDLE, RUN, DONE) SHALL live in shared package mem_stream_pkg.
REQ-023 The block SHALL be a single module with no sub-modules. It SHALL connect directly to the single-port data memory's address, write-enable, write-data and read-data ports.

Verification
REQ-024 Reset check: rst_ni=0 -> all outputs 0, IDLE.
REQ-025 Stride-1 stream: memory[i]=i+1, base=4, stride=1, length=3, ready_i=1 -> data_o 5,6,7 on consecutive cycles, last_o with 7, done_o pulses once.
REQ-026 Backpressure: the same transfer with ready_i=0 for 3 cycles at word 2 -> data_o=6 held stable, no word lost or duplicated.
REQ-027 Wrap: DataDepth=16, base=14, stride=3, length=3 -> addresses 14,1,4.
REQ-028 Zero length: length=0 -> no valid_o, done_o one cycle after start.
REQ-029 Abort and restart: start_i during RUN ignored; rst_ni pulsed mid-transfer -> valid_o=0, no done_o, next start works normally.
